// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t       : FSM state encodings (IDLE / WAIT / RESP)
//   F3_*          : RISC-V load/store funct3 codes
//   access_fmt_err: size/alignment/funct3/byte-enable legality check
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // 1 when the access cannot be performed because of its encoding,
    // independent of the address range.
    function automatic logic access_fmt_err(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] offset,
                                            input logic [3:0] amp);
        logic e;
        e = 1'b0;
        if (we) begin
            case (funct3)
                F3_SB:   e = 1'b0;
                F3_SH:   e = offset[0];
                F3_SW:   e = (offset != 2'b00);
                default: e = 1'b1;
            endcase
            if (amp == 4'b0000) e = 1'b1;
        end else begin
            case (funct3)
                F3_LB, F3_LBU: e = 1'b0;
                F3_LH, F3_LHU: e = offset[0];
                F3_LW:         e = (offset != 2'b00);
                default:       e = 1'b1;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/dmem_resp_load_extract.sv
// load_extract: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it according to the load funct3.
//   word   : 32-bit memory word
//   offset : byte offset within the word (addr[1:0])
//   funct3 : load funct3
//   result : extended load value (0 for non-load encodings)
module load_extract
    import dmem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        b       = shifted[7:0];
        h       = offset[1] ? word[31:16] : word[15:0];
        result  = '0;
        case (funct3)
            F3_LB:   result = {{24{b[7]}}, b};
            F3_LBU:  result = {24'd0, b};
            F3_LH:   result = {{16{h[15]}}, h};
            F3_LHU:  result = {16'd0, h};
            F3_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data memory with a fixed response latency.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and the
// store/load takes effect on the edge that enters RESP. RESP holds until the
// core takes the response.
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake
//   req_we, req_addr, req_funct3,
//   req_amp, req_wdata              : request payload (store data pre-laned)
//   resp_valid/resp_ready           : response handshake
//   resp_rdata, resp_err            : extended load data / rejection flag
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [3:0]  req_amp,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        we_q, err_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic [2:0]  f3_q;
    logic [3:0]  amp_q;
    logic        accept, enter_resp;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY = 0 the accept edge is also the RESP-entry edge, so the
    // access must be taken from the live request rather than the registers.
    logic             use_live;
    logic             a_we, a_err;
    logic [31:0]      a_addr, a_wdata, a_off;
    logic [2:0]       a_f3;
    logic [3:0]       a_amp;
    logic [IDX_W-1:0] a_idx;

    always_comb begin
        use_live = (state == S_IDLE);
        a_we     = use_live ? req_we     : we_q;
        a_addr   = use_live ? req_addr   : addr_q;
        a_f3     = use_live ? req_funct3 : f3_q;
        a_amp    = use_live ? req_amp    : amp_q;
        a_wdata  = use_live ? req_wdata  : wdata_q;
        a_off    = a_addr - BASE_ADDR;
        a_idx    = a_off[IDX_W+1:2];
        a_err    = (a_addr < BASE_ADDR)
                || ({2'b00, a_off[31:2]} >= 32'(DEPTH_WORDS))
                || access_fmt_err(a_we, a_f3, a_addr[1:0], a_amp);
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: if (req_valid) begin
                accept = 1'b1;
                if (LATENCY == 0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (cnt == 4'd0) begin
                state_nxt  = S_RESP;
                enter_resp = 1'b1;
            end
            S_RESP: if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                amp_q   <= req_amp;
                wdata_q <= req_wdata;
                cnt     <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q  <= a_err;
                word_q <= mem[a_idx];
            end
        end
    end

    // Storage is never reset; reset only suppresses a write on its edge.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && a_we && !a_err) begin
            for (int i = 0; i < 4; i++) begin
                if (a_amp[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    logic [31:0] ext_result;

    load_extract u_extract (
        .word   (word_q),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .result (ext_result)
    );

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (state == S_RESP) && err_q;
    assign resp_rdata = (state == S_RESP && !err_q && !we_q) ? ext_result : 32'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: table of transactions against a LATENCY=2 instance,
// hand sequences for reset-in-WAIT / reset-in-RESP, and a LATENCY=0
// instance for the held-response case. Expected responses are queued when a
// request is driven and popped when the response appears.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    localparam int LAT_A = 2, DEPTH_A = 1024;
    localparam int LAT_B = 0, DEPTH_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic [3:0]  req_amp;

    logic        reset_a, req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_err_a;
    logic [31:0] resp_rdata_a;
    logic        reset_b, req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    dmem_resp #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .reset(reset_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_amp(req_amp),
        .req_wdata(req_wdata), .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a));

    dmem_resp #(.DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B), .BASE_ADDR(32'h0)) u_b (
        .clk(clk), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_amp(req_amp),
        .req_wdata(req_wdata), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b));

    int nvec = 0;
    int nbad = 0;

    logic        sel;  // 0 = instance A, 1 = instance B
    logic        cur_req_ready, cur_resp_valid, cur_resp_err;
    logic [31:0] cur_resp_rdata;
    always_comb begin
        cur_req_ready  = sel ? req_ready_b  : req_ready_a;
        cur_resp_valid = sel ? resp_valid_b : resp_valid_a;
        cur_resp_err   = sel ? resp_err_b   : resp_err_a;
        cur_resp_rdata = sel ? resp_rdata_b : resp_rdata_a;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [3:0]  amp;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [3:0] amp, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.f3 = f3; v.amp = amp; v.wdata = wdata;
        v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input vec_t v);
        req_we = v.we; req_addr = v.addr; req_funct3 = v.f3;
        req_amp = v.amp; req_wdata = v.wdata;
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    endtask

    // One full transaction with latency, data and error checked.
    task automatic xact(input logic s, input vec_t v, input string name);
        exp_t e, got;
        int   n;
        sel     = s;
        e.rdata = v.rdata;
        e.err   = v.err;
        e.lat   = (s ? LAT_B : LAT_A) + 1;
        @(negedge clk);
        chk({name, " req_ready"}, 32'(cur_req_ready), 32'd1);
        drive(s, v);
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        n = 1;
        while (!cur_resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        got = sb.pop_front();
        chk({name, " resp_valid"}, 32'(cur_resp_valid), 32'd1);
        chk({name, " latency"}, 32'(n), 32'(got.lat));
        chk({name, " rdata"}, cur_resp_rdata, got.rdata);
        chk({name, " err"}, 32'(cur_resp_err), 32'(got.err));
        if (s) resp_ready_b = 1'b1; else resp_ready_a = 1'b1;
        @(posedge clk); #1;
        resp_ready_a = 1'b0; resp_ready_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0; req_amp = '0;
        req_valid_a = 1'b0; resp_ready_a = 1'b0; req_valid_b = 1'b0; resp_ready_b = 1'b0;
        reset_a = 1'b1; reset_b = 1'b1; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b0; reset_b = 1'b0;
        chk("reset req_ready",  32'(req_ready_a),  32'd1);
        chk("reset resp_valid", 32'(resp_valid_a), 32'd0);
        chk("reset resp_rdata", resp_rdata_a,      32'd0);
        chk("reset resp_err",   32'(resp_err_a),   32'd0);
        chk("reset req_ready b", 32'(req_ready_b), 32'd1);

        //              we    addr          f3      amp      wdata          rdata          err
        vecs.push_back(mk(1'b1, 32'h10,   F3_SW,  4'b1111, 32'hDEADBEEF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h10,   F3_LW,  4'b0000, 32'h0,        32'hDEADBEEF,  1'b0));
        vecs.push_back(mk(1'b1, 32'h13,   F3_SB,  4'b1000, 32'h80000000, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h13,   F3_LB,  4'b0000, 32'h0,        32'hFFFFFF80,  1'b0));
        vecs.push_back(mk(1'b0, 32'h13,   F3_LBU, 4'b0000, 32'h0,        32'h00000080,  1'b0));
        vecs.push_back(mk(1'b0, 32'h11,   F3_LH,  4'b0000, 32'h0,        32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 32'h12,   F3_SW,  4'b1111, 32'h12345678, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 32'h10,   F3_LW,  4'b0000, 32'h0,        32'h80ADBEEF,  1'b0));
        vecs.push_back(mk(1'b0, 32'h1000, F3_LW,  4'b0000, 32'h0,        32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 32'h12,   F3_LH,  4'b0000, 32'h0,        32'hFFFF80AD,  1'b0));
        vecs.push_back(mk(1'b0, 32'h10,   F3_LHU, 4'b0000, 32'h0,        32'h0000BEEF,  1'b0));
        vecs.push_back(mk(1'b0, 32'h11,   F3_LB,  4'b0000, 32'h0,        32'hFFFFFFBE,  1'b0));
        vecs.push_back(mk(1'b1, 32'h20,   F3_SW,  4'b1111, 32'h00000000, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 32'h22,   F3_SH,  4'b1100, 32'hABCD0000, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h20,   F3_LW,  4'b0000, 32'h0,        32'hABCD0000,  1'b0));
        vecs.push_back(mk(1'b0, 32'h10,   3'b011, 4'b0000, 32'h0,        32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 32'h20,   3'b011, 4'b1111, 32'h11111111, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 32'h20,   F3_SB,  4'b0000, 32'h22222222, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 32'h21,   F3_SH,  4'b0110, 32'h00333300, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 32'h20,   F3_LW,  4'b0000, 32'h0,        32'hABCD0000,  1'b0));
        vecs.push_back(mk(1'b0, 32'h22,   F3_LBU, 4'b0000, 32'h0,        32'h000000CD,  1'b0));

        for (int i = 0; i < vecs.size(); i++) xact(1'b0, vecs[i], $sformatf("vec%0d", i));

        // Reset while a store waits: the store must never land.
        sel = 1'b0;
        @(negedge clk);
        drive(1'b0, mk(1'b1, 32'h10, F3_SW, 4'b1111, 32'h11111111, 32'h0, 1'b0));
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        chk("wait req_ready", 32'(req_ready_a), 32'd0);
        reset_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0;
        chk("abort req_ready",  32'(req_ready_a),  32'd1);
        chk("abort resp_valid", 32'(resp_valid_a), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort stays idle", 32'(resp_valid_a), 32'd0);
        xact(1'b0, mk(1'b0, 32'h10, F3_LW, 4'b0000, 32'h0, 32'h80ADBEEF, 1'b0), "after abort");

        // Reset while a response is pending, with resp_ready also high: reset wins.
        @(negedge clk);
        drive(1'b0, mk(1'b0, 32'h20, F3_LW, 4'b0000, 32'h0, 32'h0, 1'b0));
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-drop resp_valid", 32'(resp_valid_a), 32'd1);
        reset_a = 1'b1; resp_ready_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0; resp_ready_a = 1'b0;
        chk("drop resp_valid", 32'(resp_valid_a), 32'd0);
        chk("drop resp_rdata", resp_rdata_a,      32'd0);
        chk("drop req_ready",  32'(req_ready_a),  32'd1);

        // LATENCY = 0 instance.
        xact(1'b1, mk(1'b1, 32'h4,  F3_SW, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0), "l0 store");
        xact(1'b1, mk(1'b0, 32'h40, F3_LW, 4'b0000, 32'h0,        32'h0, 1'b1), "l0 range");

        sel = 1'b1;
        @(negedge clk);
        drive(1'b1, mk(1'b0, 32'h4, F3_LW, 4'b0000, 32'h0, 32'h0, 1'b0));
        resp_ready_b = 1'b0;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        chk("l0 resp_valid", 32'(resp_valid_b), 32'd1);
        chk("l0 rdata",      resp_rdata_b,      32'hCAFEF00D);
        chk("l0 req_ready",  32'(req_ready_b),  32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("l0 hold%0d valid", i), 32'(resp_valid_b), 32'd1);
            chk($sformatf("l0 hold%0d rdata", i), resp_rdata_b,      32'hCAFEF00D);
            chk($sformatf("l0 hold%0d ready", i), 32'(req_ready_b),  32'd0);
        end
        resp_ready_b = 1'b1;
        #1;
        chk("l0 release req_ready", 32'(req_ready_b), 32'd0);
        @(posedge clk); #1;
        resp_ready_b = 1'b0;
        chk("l0 idle req_ready",  32'(req_ready_b),  32'd1);
        chk("l0 idle resp_valid", 32'(resp_valid_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, which is the number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, which is the number of wait cycles between request accept and response, legal range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, which is the byte address of word 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32 bits: the byte address.
REQ-010 SHALL have port req_funct3, input, 3 bits: the RISC-V load/store funct3 (size and sign).
REQ-011 SHALL have port req_amp, input, 4 bits: the store byte-lane enables, one per byte, bit0 = byte 0.
REQ-012 SHALL have port req_wdata, input, 32 bits: the store data, already placed in its byte lanes.
REQ-013 SHALL have port resp_valid, output, 1 bit: a response is pending.
REQ-014 SHALL have port resp_ready, input, 1 bit: the core consumes the response.
REQ-015 SHALL have port resp_rdata, output, 32 bits: the load result, extracted and extended; 0 for stores and errors.
REQ-016 SHALL have port resp_err, output, 1 bit: the access was rejected.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE, and resp_valid = 1 only in RESP.
REQ-018 SHALL accept a request on a cycle with req_valid && req_ready, registering req_we, req_addr, req_funct3, req_amp and req_wdata.
REQ-019 SHALL, on accept, go to WAIT and load the wait counter with LATENCY-1 when LATENCY > 0; when LATENCY = 0 it SHALL go directly to RESP.
REQ-020 SHALL decrement the counter each WAIT cycle and go to RESP on the cycle after the counter reads 0, so resp_valid asserts exactly LATENCY+1 cycles after the accept edge.
REQ-021 SHALL hold RESP, with resp_rdata and resp_err stable, until resp_ready = 1, then return to IDLE on the next edge; a new request is accepted no earlier than the following cycle.
REQ-022 SHALL perform a store's write to the array on the edge of entry into RESP, never earlier; a load SHALL sample the array on that same edge.
REQ-023 SHALL compute word index = (addr - BASE_ADDR) >> 2; an index >= DEPTH_WORDS or addr < BASE_ADDR SHALL be an error.
REQ-024 SHALL flag these funct3 and alignment cases as errors: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0; loads with funct3 not in {000, 001, 010, 100, 101}; stores with funct3 not in {000, 001, 010}; stores with req_amp = 0.
REQ-025 SHALL, on error, leave the array unmodified and drive resp_err = 1 and resp_rdata = 0.
REQ-026 SHALL write a store to only the bytes whose req_amp bit is set.
REQ-027 SHALL extract a load at the byte offset addr[1:0] (byte) or addr[1] (half): LB/LH sign-extend, LBU/LHU zero-extend, LW returns the word.
REQ-028 SHALL ignore req_valid outside IDLE; it SHALL NOT be queued.

Reset
REQ-029 SHALL, on reset, force state = IDLE and counter = 0, giving req_ready = 1, resp_valid = 0, resp_rdata = 0 and resp_err = 0 on the following cycle.
REQ-030 SHALL, on reset during WAIT, abort the transaction so the pending store never writes; reset during RESP SHALL drop the response.
REQ-031 SHALL NOT clear the array contents on reset.
REQ-032 SHALL give reset priority over every simultaneous event, including accept and resp_ready.

Structure
REQ-033 SHALL define the FSM state encodings and the funct3 load/store codes (LB, LH, LW, LBU, LHU, SB, SH, SW) in the shared defines file.
REQ-034 SHALL implement load extraction and extension as one combinational sub-module, load_extract, with inputs word, offset and funct3, and output result.
REQ-035 SHALL implement the storage as an inferred array of DEPTH_WORDS × 32 bits with per-byte write.

Verification
REQ-036 SHALL test: SW addr 0x10, data 0xDEADBEEF, amp 1111, LATENCY 2 -> resp_valid 3 cycles after accept, err 0; a following LW at 0x10 returns 0xDEADBEEF.
REQ-037 SHALL test: SB addr 0x13, wdata 0x80000000, amp 1000, then LB at 0x13 -> 0xFFFFFF80 and LBU at 0x13 -> 0x00000080.
REQ-038 SHALL test: LH at 0x11 -> resp_err 1, rdata 0; SW at 0x12 -> err 1 and the word at 0x10 is unchanged.
REQ-039 SHALL test: LW at BASE + 4*DEPTH_WORDS -> err 1.
REQ-040 SHALL test: SW accepted, reset asserted in WAIT -> idle with req_ready = 1 the next cycle; a later LW shows the old data.
REQ-041 SHALL test: LATENCY 0 with resp_ready held low for 3 cycles -> resp_valid is asserted the cycle after accept, stays asserted with stable data, and req_ready stays 0 until the cycle after resp_ready goes high.
